// File: rtl/sum_uart_formatter.sv
// sum_uart_formatter
// Watches the 5-bit adder sum and waits until it has settled. Each new settled
// value is sent to uart_tx as a 4-byte ASCII frame: tens digit, ones digit,
// CR, LF. One frame is also sent after reset, once the input settles.
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset (aborts any frame in progress)
//   sum_in       sum from the adder (SUM_W bits, maximum value must be <= 99)
//   tx_busy      uart_tx busy flag
//   tx_en        one-cycle byte-start pulse to uart_tx
//   tx_data      byte to uart_tx, held from issue until the next issue
//   frame_busy   high while a frame is in progress
//   frames_sent  count of completed frames, wraps 255 -> 0
//
// Optional build macro SUM_UART_RESEND_EN adds parameter RESEND_CYCLES. With
// it, the last sent frame is sent again after RESEND_CYCLES idle cycles even
// if the sum has not changed.
module sum_uart_formatter #(
    parameter int SUM_W         = 5,
    parameter int STABLE_CYCLES = 16,
    parameter int ACK_WAIT      = 4
`ifdef SUM_UART_RESEND_EN
    ,
    parameter int RESEND_CYCLES = 1_000_000
`endif
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [SUM_W-1:0] sum_in,
    input  logic             tx_busy,
    output logic             tx_en,
    output logic [7:0]       tx_data,
    output logic             frame_busy,
    output logic [7:0]       frames_sent
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int ACK_W = $clog2(ACK_WAIT + 1);
    localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [ACK_W-1:0] ACK_MAX    = ACK_W'(ACK_WAIT);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    // ASCII byte at position idx of the frame for a value 0..99.
    function automatic logic [7:0] frame_byte(input logic [7:0] value, input logic [1:0] idx);
        logic [7:0] byte_v;
        case (idx)
            2'd0:    byte_v = 8'h30 + (value / 8'd10);
            2'd1:    byte_v = 8'h30 + (value % 8'd10);
            2'd2:    byte_v = 8'h0D;
            2'd3:    byte_v = 8'h0A;
            default: byte_v = 8'h0A;
        endcase
        return byte_v;
    endfunction

    logic [SUM_W-1:0] sum_q_r;
    logic [CNT_W-1:0] stab_cnt_r;
    logic             settled_s;
    logic             new_value_s;
    logic             resend_s;
    logic             start_s;

    state_t           state_r, state_nx;
    logic [1:0]       idx_r, idx_nx;
    logic [SUM_W-1:0] snap_r, snap_nx;
    logic [SUM_W-1:0] last_sent_r, last_sent_nx;
    logic             init_pend_r, init_pend_nx;
    logic [ACK_W-1:0] ack_cnt_r, ack_cnt_nx;
    logic             tx_en_r, tx_en_nx;
    logic [7:0]       tx_data_r, tx_data_nx;
    logic             frame_busy_r, frame_busy_nx;
    logic [7:0]       frames_sent_r, frames_sent_nx;
    logic [7:0]       snap8_s;

    // Settling filter: counts consecutive cycles sum_in matched its registered copy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_q_r    <= '0;
            stab_cnt_r <= '0;
        end else begin
            sum_q_r <= sum_in;
            if (sum_in != sum_q_r) begin
                stab_cnt_r <= '0;
            end else if (stab_cnt_r != STABLE_MAX) begin
                stab_cnt_r <= stab_cnt_r + CNT_W'(1);
            end else begin
                stab_cnt_r <= stab_cnt_r;
            end
        end
    end

    assign settled_s   = (stab_cnt_r == STABLE_MAX);
    assign new_value_s = settled_s && ((sum_q_r != last_sent_r) || init_pend_r);
    assign start_s     = (state_r == IDLE) && (new_value_s || resend_s);
    assign snap8_s     = {{(8-SUM_W){1'b0}}, snap_r};

`ifdef SUM_UART_RESEND_EN
    logic [31:0] idle_cnt_r;

    // Idle timer: counts cycles spent in IDLE since the last frame start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt_r <= 32'd0;
        end else if (start_s) begin
            idle_cnt_r <= 32'd0;
        end else if (state_r == IDLE) begin
            idle_cnt_r <= idle_cnt_r + 32'd1;
        end else begin
            idle_cnt_r <= idle_cnt_r;
        end
    end

    assign resend_s = (idle_cnt_r == 32'(RESEND_CYCLES));
`else
    assign resend_s = 1'b0;
`endif

    // Frame sequencer next-state and registered-output values.
    always_comb begin
        state_nx       = state_r;
        idx_nx         = idx_r;
        snap_nx        = snap_r;
        last_sent_nx   = last_sent_r;
        init_pend_nx   = init_pend_r;
        ack_cnt_nx     = ack_cnt_r;
        tx_en_nx       = 1'b0;
        tx_data_nx     = tx_data_r;
        frame_busy_nx  = frame_busy_r;
        frames_sent_nx = frames_sent_r;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    // A timed resend repeats the last frame, not a possibly unsettled input.
                    if (new_value_s) begin
                        snap_nx = sum_q_r;
                    end else begin
                        snap_nx = last_sent_r;
                    end
                    idx_nx        = 2'd0;
                    frame_busy_nx = 1'b1;
                    state_nx      = LOAD;
                end else begin
                    state_nx = IDLE;
                end
            end
            LOAD: begin
                if (!tx_busy) begin
                    tx_data_nx = frame_byte(snap8_s, idx_r);
                    tx_en_nx   = 1'b1;
                    ack_cnt_nx = '0;
                    state_nx   = WAIT_ACK;
                end else begin
                    state_nx = LOAD;
                end
            end
            WAIT_ACK: begin
                // Proceed anyway after ACK_WAIT cycles in case the start was lost.
                if (tx_busy || ((ack_cnt_r + ACK_W'(1)) == ACK_MAX)) begin
                    state_nx = WAIT_DONE;
                end else begin
                    ack_cnt_nx = ack_cnt_r + ACK_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    if (idx_r == 2'd3) begin
                        last_sent_nx   = snap_r;
                        init_pend_nx   = 1'b0;
                        frames_sent_nx = frames_sent_r + 8'd1;
                        frame_busy_nx  = 1'b0;
                        state_nx       = IDLE;
                    end else begin
                        idx_nx   = idx_r + 2'd1;
                        state_nx = LOAD;
                    end
                end else begin
                    state_nx = WAIT_DONE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Sequencer state and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= IDLE;
            idx_r         <= 2'd0;
            snap_r        <= '0;
            last_sent_r   <= '0;
            init_pend_r   <= 1'b1;
            ack_cnt_r     <= '0;
            tx_en_r       <= 1'b0;
            tx_data_r     <= 8'h00;
            frame_busy_r  <= 1'b0;
            frames_sent_r <= 8'd0;
        end else begin
            state_r       <= state_nx;
            idx_r         <= idx_nx;
            snap_r        <= snap_nx;
            last_sent_r   <= last_sent_nx;
            init_pend_r   <= init_pend_nx;
            ack_cnt_r     <= ack_cnt_nx;
            tx_en_r       <= tx_en_nx;
            tx_data_r     <= tx_data_nx;
            frame_busy_r  <= frame_busy_nx;
            frames_sent_r <= frames_sent_nx;
        end
    end

    assign tx_en       = tx_en_r;
    assign tx_data     = tx_data_r;
    assign frame_busy  = frame_busy_r;
    assign frames_sent = frames_sent_r;

endmodule

// File: tb/tb_sum_uart_formatter.sv
// Testbench for sum_uart_formatter: a UART model answers tx_en pulses with a
// busy window, and a scoreboard queue holds the frame bytes expected next.
module tb_sum_uart_formatter;

    localparam int SUM_W = 5;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [SUM_W-1:0] sum_in;
    logic             tx_busy;
    logic             tx_en;
    logic [7:0]       tx_data;
    logic             frame_busy;
    logic [7:0]       frames_sent;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_frames = 8'd0;
    int         busy_len   = 10;   // 0 means the UART never raises busy
    int         busy_cnt   = 0;
    int         bytes_seen = 0;
    int         cyc        = 0;
    int         last_en_cyc = 0;
    int         prev_en_cyc = 0;
    logic       prev_en    = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    always #5 clk = ~clk;

    sum_uart_formatter dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sum_in      (sum_in),
        .tx_busy     (tx_busy),
        .tx_en       (tx_en),
        .tx_data     (tx_data),
        .frame_busy  (frame_busy),
        .frames_sent (frames_sent)
    );

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checki(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic [15:0] digits);
        exp_q.push_back(digits[15:8]);
        exp_q.push_back(digits[7:0]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_bytes(input int target, input string name);
        int n;
        n = 0;
        while (bytes_seen < target && n < 400) begin
            @(negedge clk);
            n++;
        end
        checki({name, "_timeout"}, (bytes_seen >= target) ? 1 : 0, 1);
    endtask

    task automatic check_idle(input string name);
        checki({name, "_queue_left"}, exp_q.size(), 0);
        check8({name, "_frames_sent"}, frames_sent, exp_frames);
        check8({name, "_frame_busy"}, {7'd0, frame_busy}, 8'd0);
    endtask

    // UART model and output monitor, sampled 1 time unit after each rising edge.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!reset_n) begin
                busy_cnt = 0;
                tx_busy  = 1'b0;
                prev_en  = 1'b0;
            end else begin
                if (tx_busy) check8("data_stable_while_busy", tx_data, prev_data);
                if (tx_en) begin
                    check8("tx_en_width", {7'd0, prev_en}, 8'd0);
                    check8("busy_low_at_tx_en", {7'd0, tx_busy}, 8'd0);
                    bytes_seen++;
                    prev_en_cyc = last_en_cyc;
                    last_en_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_tx_en: got byte %h, expected no byte", tx_data);
                    end else begin
                        check8("frame_byte", tx_data, exp_q.pop_front());
                    end
                    if (busy_len > 0) begin
                        tx_busy  = 1'b1;
                        busy_cnt = busy_len;
                    end
                end else if (busy_cnt > 0) begin
                    busy_cnt--;
                    if (busy_cnt == 0) tx_busy = 1'b0;
                end
                prev_en   = tx_en;
                prev_data = tx_data;
            end
        end
    end

    typedef struct {
        logic [SUM_W-1:0] sum;
        int               busy;
        logic [15:0]      digits;
        logic             frame;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int base;
        int t0;

        vecs[0] = '{5'd0,  10, "00", 1'b1};   // initial frame after reset
        vecs[1] = '{5'd17, 10, "17", 1'b1};
        vecs[2] = '{5'd17, 3,  "--", 1'b0};   // unchanged sum, no frame
        vecs[3] = '{5'd31, 0,  "31", 1'b1};   // UART never busy, ack timeout path
        vecs[4] = '{5'd9,  3,  "09", 1'b1};
        vecs[5] = '{5'd10, 10, "10", 1'b1};

        reset_n = 1'b0;
        sum_in  = 5'd0;
        wait_cycles(3);
        check8("reset_tx_en", {7'd0, tx_en}, 8'd0);
        check8("reset_tx_data", tx_data, 8'h00);
        check8("reset_frame_busy", {7'd0, frame_busy}, 8'd0);
        check8("reset_frames_sent", frames_sent, 8'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            busy_len = vecs[i].busy;
            sum_in   = vecs[i].sum;
            if (vecs[i].frame) begin
                push_frame(vecs[i].digits);
                exp_frames++;
            end
            wait_cycles((i == 0) ? 2000 : 200);
            check_idle($sformatf("vec%0d", i));
        end

        // Glitch shorter than the settle time produces nothing.
        busy_len = 10;
        sum_in = 5'd5;
        wait_cycles(3);
        sum_in = 5'd10;
        wait_cycles(100);
        check_idle("glitch");

        // Latency and ack-timeout spacing with a UART that never goes busy.
        busy_len = 0;
        base = bytes_seen;
        t0 = cyc;
        sum_in = 5'd25;
        push_frame("25");
        exp_frames++;
        wait_bytes(base + 1, "lat_first");
        checki("settle_to_tx_en_cycles", last_en_cyc - t0, 19);
        wait_bytes(base + 2, "lat_second");
        checki("ack_timeout_gap", last_en_cyc - prev_en_cyc, 6);
        wait_cycles(100);
        check_idle("ack_timeout");

        // Sum changes during idx1: current frame completes from the snapshot.
        busy_len = 10;
        base = bytes_seen;
        sum_in = 5'd17;
        push_frame("17");
        exp_frames++;
        wait_bytes(base + 2, "midframe");
        sum_in = 5'd30;
        push_frame("30");
        exp_frames++;
        wait_cycles(300);
        check_idle("midframe");

        // Value settles elsewhere then returns to last_sent before frame end.
        base = bytes_seen;
        sum_in = 5'd9;
        push_frame("09");
        exp_frames++;
        wait_bytes(base + 1, "return");
        sum_in = 5'd20;
        wait_cycles(20);
        sum_in = 5'd9;
        wait_cycles(200);
        check_idle("return_to_last");

        // Reset during WAIT_DONE of idx2 aborts the frame at once.
        base = bytes_seen;
        sum_in = 5'd3;
        push_frame("03");
        exp_frames++;
        wait_bytes(base + 3, "abort");
        wait_cycles(3);
        reset_n = 1'b0;
        #1;
        check8("abort_tx_en", {7'd0, tx_en}, 8'd0);
        check8("abort_frame_busy", {7'd0, frame_busy}, 8'd0);
        check8("abort_frames_sent", frames_sent, 8'd0);
        exp_q.delete();
        exp_frames = 8'd0;
        sum_in = 5'd12;
        wait_cycles(3);
        reset_n = 1'b1;
        push_frame("12");
        exp_frames++;
        wait_cycles(200);
        check_idle("after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sum_uart_formatter.md
Name: sum_uart_formatter

Overview:
- Sits between the 4-bit adder and uart_tx.
- Watches the 5-bit sum and waits for it to settle.
- Converts a settled sum to a 4-byte ASCII frame: tens digit, ones digit, CR, LF.
- Sends the frame byte by byte to uart_tx using a one-cycle enable pulse and the busy handshake. A frame goes out only on a settled change, plus one initial frame after reset.

Parameters:
- SUM_W, 5, width of sum_in (max value 2^SUM_W-1 must be ≤ 99).
- STABLE_CYCLES, 16, consecutive cycles sum_in must hold before it counts as settled.
- ACK_WAIT, 4, cycles to wait for tx_busy to rise after a tx_en pulse before proceeding anyway.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- sum_in  in  SUM_W  sum from the adder.
- tx_busy  in  1  uart_tx busy flag.
- tx_en  out  1  one-cycle byte-start pulse to uart_tx.
- tx_data  out  8  byte to uart_tx.
- frame_busy  out  1  high while a frame is in progress.
- frames_sent  out  8  count of completed frames, wraps 255→0.

Behaviour:
- Reset (async, reset_n=0): all outputs 0; state=IDLE; last_sent=0; init_pend=1; stab_cnt=0. Asserting reset mid-frame aborts the frame immediately. After reset_n releases, an initial frame is sent once the input settles.
- Settling filter:
  - sum_q registers sum_in every cycle.
  - stab_cnt clears when sum_in≠sum_q, otherwise increments, saturating at STABLE_CYCLES.
  - settled = (stab_cnt==STABLE_CYCLES).
- State IDLE:
  - Start condition: settled && (sum_q≠last_sent || init_pend).
  - On start: snap←sum_q; tens←snap/10; ones←snap%10; idx←0; frame_busy←1; next LOAD.
- Byte order:
  - idx0 = 0x30+tens
  - idx1 = 0x30+ones
  - idx2 = 0x0D
  - idx3 = 0x0A
  - Example: sum 7 sends "07"; sum 31 sends "31".
- State LOAD: waits while tx_busy=1. When tx_busy=0: tx_data←byte[idx], tx_en=1 for exactly one cycle, wait counter cleared, next WAIT_ACK.
- State WAIT_ACK: tx_en=0. tx_busy=1 → WAIT_DONE. Otherwise the counter increments; when it reaches ACK_WAIT → WAIT_DONE (guards against a lost start).
- State WAIT_DONE: waits for tx_busy=0, then:
  - idx<3: idx++ and next LOAD.
  - idx==3: last_sent←snap, init_pend←0, frames_sent++, frame_busy←0, next IDLE.
- tx_data holds its value from issue until the next LOAD issue. It is never changed while tx_busy=1.
- sum_in changes mid-frame are ignored for the current frame, since snap is used. The filter keeps running, so a new settled value sends a frame right after returning to IDLE.
- A value that changes and then returns to last_sent before the frame ends produces no extra frame.
- Latency: settled-to-first tx_en is 2 cycles when tx_busy=0 (IDLE→LOAD→pulse).

Optional Feature:
- Macro SUM_UART_RESEND_EN, adds parameter RESEND_CYCLES (default 1_000_000).
- Defined:
  - A 32-bit idle counter increments in IDLE and clears on any frame start.
  - When it reaches RESEND_CYCLES, the last_sent frame is retransmitted even if the sum is unchanged. frames_sent increments as normal.
  - Counter resets to 0 on reset.
- Undefined: no counter; frames are sent only on a change or the initial frame.

Test Plan:
1. Reset; sum_in=0 held; UART model keeps busy high 10 cycles per byte → exactly one frame 0x30,0x30,0x0D,0x0A; frames_sent=1; no further tx_en in 2000 cycles.
2. After test 1, sum_in=17 held → after 16 stable cycles, frame 0x31,0x37,0x0D,0x0A; frames_sent=2; each tx_en exactly 1 cycle wide with tx_busy=0 at the pulse.
3. Glitch: sum_in=5 for 3 cycles, then back to 17 → no frame; frames_sent unchanged.
4. sum_in 17→30 during byte idx1 of a "17" frame → "17\r\n" completes intact, then "30\r\n" follows; frames_sent +2.
5. UART model never raises tx_busy → each byte advances after ACK_WAIT=4 cycles; 4 tx_en pulses per frame; frame_busy falls; FSM returns to IDLE.
6. reset_n low during WAIT_DONE of idx2 → tx_en=0, frame_busy=0, frames_sent=0 in the same cycle; after release with sum_in=12, the initial frame "12\r\n" is sent. With SUM_UART_RESEND_EN and RESEND_CYCLES=100: unchanged sum → frame repeats every ~100 idle cycles.
